// File: rtl/aes_byte_loader.sv
`default_nettype none
// ============================================================================
// Module   : aes_byte_loader
// Purpose  : Byte-stream front end for AES_top. Collects a 16-byte plaintext
//            and, optionally, a 16-byte key over a valid/ready handshake into
//            shadow registers. It then hands them to the core with a one-cycle
//            start pulse. Because the registers are shadowed, the next job can
//            load while the core is still encrypting.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            in_valid/in_ready   - byte-stream handshake
//            in_data             - stream byte
//            in_key_reuse        - sampled with first PT byte: reuse last key
//            plain_text          - 128-bit plaintext to the core
//            cipher_key          - 128-bit key to the core
//            start               - one-cycle start pulse to the core
//            done                - completion pulse from the core
//            busy                - core is encrypting
//            job_count           - completed jobs, wraps modulo 2^JOB_CNT_W
//            err_spurious_done   - sticky, done seen while not busy
// Revision : 1.0 - initial release
// ============================================================================
module aes_byte_loader #(
    parameter int JOB_CNT_W = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 in_key_reuse,
    output logic [127:0]         plain_text,
    output logic [127:0]         cipher_key,
    output logic                 start,
    input  logic                 done,
    output logic                 busy,
    output logic [JOB_CNT_W-1:0] job_count,
    output logic                 err_spurious_done
);

    // Collector states
    localparam logic [1:0] S_COLLECT_PT  = 2'd0;
    localparam logic [1:0] S_COLLECT_KEY = 2'd1;
    localparam logic [1:0] S_PENDING     = 2'd2;

    localparam logic [3:0] c_LAST_BYTE   = 4'd15;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 w_in_ready;

    logic [3:0]           r_cnt;
    logic                 r_key_loaded;
    logic                 r_reuse;
    logic [127:0]         r_shadow_pt;
    logic [127:0]         r_shadow_key;
    logic [127:0]         r_plain_text;
    logic [127:0]         r_cipher_key;
    logic                 r_start;
    logic                 r_busy;
    logic [JOB_CNT_W-1:0] r_job_count;
    logic                 r_err_spurious_done;

    logic                 w_accept;
    logic                 w_last_byte;
    logic                 w_transfer;
    logic [3:0]           w_pos;
    logic [6:0]           w_bit_base;

    assign w_accept    = in_valid & w_in_ready;
    assign w_last_byte = (r_cnt == c_LAST_BYTE);
    // A pending job may only move into the core registers while the core is idle.
    assign w_transfer  = (r_state == S_PENDING) & ~r_busy;

    // Byte lane of the current byte: first byte either at the top or bottom.
    assign w_pos       = MSB_FIRST ? (c_LAST_BYTE - r_cnt) : r_cnt;
    assign w_bit_base  = {w_pos, 3'b000};

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_COLLECT_PT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT_PT: begin
                // r_reuse was latched on byte 0, so it is valid by byte 15.
                if (w_accept && w_last_byte) begin
                    w_state_nxt = r_reuse ? S_PENDING : S_COLLECT_KEY;
                end
            end
            S_COLLECT_KEY: begin
                if (w_accept && w_last_byte) begin
                    w_state_nxt = S_PENDING;
                end
            end
            S_PENDING: begin
                if (!r_busy) begin
                    w_state_nxt = S_COLLECT_PT;
                end
            end
            default: w_state_nxt = S_COLLECT_PT;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_in_ready = 1'b0;
        if (!rst && (r_state == S_COLLECT_PT || r_state == S_COLLECT_KEY)) begin
            w_in_ready = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: shadow assembly, core hand-off and core tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt               <= 4'd0;
            r_key_loaded        <= 1'b0;
            r_reuse             <= 1'b0;
            r_shadow_pt         <= '0;
            r_shadow_key        <= '0;
            r_plain_text        <= '0;
            r_cipher_key        <= '0;
            r_start             <= 1'b0;
            r_busy              <= 1'b0;
            r_job_count         <= '0;
            r_err_spurious_done <= 1'b0;
        end else begin
            if (w_accept) begin
                // 4-bit counter wraps 15 -> 0 at the end of each block.
                r_cnt <= r_cnt + 4'd1;
                if (r_state == S_COLLECT_PT) begin
                    r_shadow_pt[w_bit_base +: 8] <= in_data;
                    if (r_cnt == 4'd0) begin
                        // A reuse request without any key loaded yet is ignored.
                        r_reuse <= in_key_reuse & r_key_loaded;
                    end
                end else begin
                    r_shadow_key[w_bit_base +: 8] <= in_data;
                    if (w_last_byte) begin
                        r_key_loaded <= 1'b1;
                    end
                end
            end

            r_start <= w_transfer;

            // The shadow key still holds the previous key on a reuse job, so
            // copying it unconditionally keeps cipher_key unchanged.
            if (w_transfer) begin
                r_plain_text <= r_shadow_pt;
                r_cipher_key <= r_shadow_key;
                r_busy       <= 1'b1;
            end else if (done && r_busy) begin
                r_busy      <= 1'b0;
                r_job_count <= r_job_count + JOB_CNT_W'(1);
            end

            if (done && !r_busy) begin
                r_err_spurious_done <= 1'b1;
            end
        end
    end

    assign in_ready          = w_in_ready;
    assign plain_text        = r_plain_text;
    assign cipher_key        = r_cipher_key;
    assign start             = r_start;
    assign busy              = r_busy;
    assign job_count         = r_job_count;
    assign err_spurious_done = r_err_spurious_done;

endmodule
`default_nettype wire

// File: tb/tb_aes_byte_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_byte_loader
// Purpose  : Self-checking bench for aes_byte_loader. Random jobs are checked
//            against a behavioural model that assembles words from the byte
//            stream, remembers the last key and counts completed jobs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_byte_loader;

    localparam int JOB_CNT_W = 16;
    localparam bit MSB_FIRST = 1'b1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [7:0]           in_data = 8'h00;
    logic                 in_key_reuse = 1'b0;
    logic [127:0]         plain_text;
    logic [127:0]         cipher_key;
    logic                 start;
    logic                 done = 1'b0;
    logic                 busy;
    logic [JOB_CNT_W-1:0] job_count;
    logic                 err_spurious_done;

    aes_byte_loader #(
        .JOB_CNT_W (JOB_CNT_W),
        .MSB_FIRST (MSB_FIRST)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .in_key_reuse      (in_key_reuse),
        .plain_text        (plain_text),
        .cipher_key        (cipher_key),
        .start             (start),
        .done              (done),
        .busy              (busy),
        .job_count         (job_count),
        .err_spurious_done (err_spurious_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Start-pulse monitor: counts high cycles of start and captures outputs.
    int           start_cnt = 0;
    int           last_start_cyc = -1;
    logic [127:0] last_pt = '0;
    logic [127:0] last_key = '0;
    always @(negedge clk) begin
        if (start === 1'b1) begin
            start_cnt      = start_cnt + 1;
            last_start_cyc = cyc;
            last_pt        = plain_text;
            last_key       = cipher_key;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [127:0] m_key = '0;
    bit           m_key_loaded = 1'b0;
    int           m_jobs = 0;
    bit           m_busy = 1'b0;
    logic [127:0] exp_pt = '0;
    logic [127:0] exp_key = '0;
    int           acc_cyc = 0;
    int           done_cyc = 0;

    // Stream word: byte i of the stream is stream[127-8i -: 8].
    function automatic logic [127:0] assemble(input logic [127:0] stream);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = stream[127-8*i -: 8];
            if (MSB_FIRST) r = {r[119:0], b};
            else           r = {b, r[127:8]};
        end
        return r;
    endfunction

    task automatic model_reset();
        m_key = '0; m_key_loaded = 1'b0; m_jobs = 0; m_busy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic reuse, input int gap);
        int guard;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1; in_data = b; in_key_reuse = reuse;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 400) begin
            n_vec++; n_err++;
            $display("FAIL send_byte_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_key_reuse = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic send_job(input logic [127:0] pt, input logic [127:0] key,
                            input logic reuse_req, input int max_gap);
        bit reuse_eff;
        reuse_eff = reuse_req && m_key_loaded;
        for (int i = 0; i < 16; i++)
            send_byte(pt[127-8*i -: 8], (i == 0) ? reuse_req : 1'($urandom_range(0, 1)),
                      $urandom_range(0, max_gap));
        exp_pt = assemble(pt);
        if (!reuse_eff) begin
            for (int i = 0; i < 16; i++)
                send_byte(key[127-8*i -: 8], 1'($urandom_range(0, 1)), $urandom_range(0, max_gap));
            m_key = assemble(key);
            m_key_loaded = 1'b1;
        end
        exp_key = m_key;
    endtask

    task automatic wait_start(input int target, output bit ok);
        int g;
        g = 0;
        while (start_cnt < target && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        ok = (start_cnt >= target);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        done_cyc = cyc;
        if (m_busy) begin
            m_jobs = (m_jobs + 1) % (1 << JOB_CNT_W);
            m_busy = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_vec++;
        if ({plain_text, cipher_key} !== 256'h0) begin
            n_err++; $display("FAIL reset_outputs got=%h %h want=0", plain_text, cipher_key);
        end
        n_vec++;
        if ({start, busy, err_spurious_done, in_ready} !== 4'b0001 || job_count !== '0) begin
            n_err++; $display("FAIL reset_flags got=%b%b%b%b jc=%0d want=0001 jc=0",
                              start, busy, err_spurious_done, in_ready, job_count);
        end
    endtask

    task automatic test_single_job();
        int s0; bit ok;
        s0 = start_cnt;
        send_job(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 0);
        wait_start(s0 + 1, ok);
        m_busy = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (!ok || start_cnt != s0 + 1) begin
            n_err++; $display("FAIL single_start_count got=%0d want=%0d", start_cnt - s0, 1);
        end
        n_vec++;
        if (last_start_cyc != acc_cyc + 1) begin
            n_err++; $display("FAIL single_latency got=%0d want=%0d", last_start_cyc, acc_cyc + 1);
        end
        n_vec++;
        if (last_pt !== exp_pt || last_key !== exp_key) begin
            n_err++; $display("FAIL single_data got=%h %h want=%h %h", last_pt, last_key, exp_pt, exp_key);
        end
        repeat (9) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL single_busy got=%b want=1", busy);
        end
        pulse_done();
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || job_count !== JOB_CNT_W'(m_jobs)) begin
            n_err++; $display("FAIL single_done got busy=%b jc=%0d want busy=0 jc=%0d", busy, job_count, m_jobs);
        end
    endtask

    task automatic test_key_reuse();
        int s0; bit ok;
        s0 = start_cnt;
        send_job({16{8'hff}}, 128'h0, 1'b1, 0);
        wait_start(s0 + 1, ok);
        m_busy = 1'b1;
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL reuse_start got=%0d want=%0d", start_cnt - s0, 1);
        end
        n_vec++;
        if (last_pt !== {16{8'hff}} || last_key !== 128'h000102030405060708090a0b0c0d0e0f) begin
            n_err++; $display("FAIL reuse_data got=%h %h want=%h %h", last_pt, last_key,
                              {16{8'hff}}, 128'h000102030405060708090a0b0c0d0e0f);
        end
        pulse_done();
    endtask

    task automatic test_reuse_before_key();
        int s0; bit ok; logic [127:0] k;
        do_reset();
        s0 = start_cnt;
        for (int i = 0; i < 16; i++) send_byte(8'(i * 3 + 1), (i == 0) ? 1'b1 : 1'b0, 0);
        repeat (3) @(negedge clk);
        n_vec++;
        if (start_cnt != s0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL reuse_nokey_early got starts=%0d rdy=%b want starts=0 rdy=1",
                              start_cnt - s0, in_ready);
        end
        k = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 16; i++) send_byte(k[127-8*i -: 8], 1'b0, 0);
        exp_key = assemble(k);
        m_key = exp_key; m_key_loaded = 1'b1;
        for (int i = 0; i < 16; i++) exp_pt[127-8*i -: 8] = 8'(i * 3 + 1);
        exp_pt = assemble(exp_pt);
        wait_start(s0 + 1, ok);
        m_busy = 1'b1;
        n_vec++;
        if (!ok || last_pt !== exp_pt || last_key !== exp_key) begin
            n_err++; $display("FAIL reuse_nokey_data got=%h %h want=%h %h", last_pt, last_key, exp_pt, exp_key);
        end
        pulse_done();
    endtask

    task automatic test_back_to_back();
        int s0; bit ok; logic [127:0] j1_pt, j1_key;
        s0 = start_cnt;
        send_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1);
        wait_start(s0 + 1, ok);
        m_busy = 1'b1;
        j1_pt = exp_pt; j1_key = exp_key;
        send_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0);
        repeat (3) @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0 || start_cnt != s0 + 1) begin
            n_err++; $display("FAIL b2b_backpressure got rdy=%b starts=%0d want rdy=0 starts=1",
                              in_ready, start_cnt - s0);
        end
        n_vec++;
        if (plain_text !== j1_pt || cipher_key !== j1_key) begin
            n_err++; $display("FAIL b2b_hold got=%h %h want=%h %h", plain_text, cipher_key, j1_pt, j1_key);
        end
        pulse_done();
        wait_start(s0 + 2, ok);
        m_busy = 1'b1;
        n_vec++;
        if (!ok || last_start_cyc != done_cyc + 1) begin
            n_err++; $display("FAIL b2b_restart got cyc=%0d want cyc=%0d", last_start_cyc, done_cyc + 1);
        end
        n_vec++;
        if (last_pt !== exp_pt || last_key !== exp_key) begin
            n_err++; $display("FAIL b2b_data got=%h %h want=%h %h", last_pt, last_key, exp_pt, exp_key);
        end
        pulse_done();
    endtask

    task automatic test_reset_mid_stream();
        int s0; bit ok;
        for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b0, 0);
        do_reset();
        @(negedge clk);
        n_vec++;
        if (job_count !== '0 || plain_text !== '0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midrst_clear got jc=%0d pt=%h busy=%b want 0", job_count, plain_text, busy);
        end
        s0 = start_cnt;
        send_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)), 0);
        wait_start(s0 + 1, ok);
        m_busy = 1'b1;
        n_vec++;
        if (!ok || last_pt !== exp_pt || last_key !== exp_key || job_count !== '0) begin
            n_err++; $display("FAIL midrst_job got=%h %h jc=%0d want=%h %h jc=0",
                              last_pt, last_key, job_count, exp_pt, exp_key);
        end
        pulse_done();
        @(negedge clk);
        n_vec++;
        if (job_count !== JOB_CNT_W'(m_jobs)) begin
            n_err++; $display("FAIL midrst_count got=%0d want=%0d", job_count, m_jobs);
        end
    endtask

    task automatic test_spurious_done();
        pulse_done();
        @(negedge clk);
        n_vec++;
        if (err_spurious_done !== 1'b1 || job_count !== JOB_CNT_W'(m_jobs)) begin
            n_err++; $display("FAIL spurious_set got err=%b jc=%0d want err=1 jc=%0d",
                              err_spurious_done, job_count, m_jobs);
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if (err_spurious_done !== 1'b1) begin
            n_err++; $display("FAIL spurious_sticky got=%b want=1", err_spurious_done);
        end
        do_reset();
        @(negedge clk);
        n_vec++;
        if (err_spurious_done !== 1'b0) begin
            n_err++; $display("FAIL spurious_clear got=%b want=0", err_spurious_done);
        end
    endtask

    task automatic test_random_jobs();
        int s0; bit ok;
        for (int j = 0; j < 8; j++) begin
            s0 = start_cnt;
            send_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                     1'($urandom_range(0, 1)), 2);
            wait_start(s0 + 1, ok);
            m_busy = 1'b1;
            n_vec++;
            if (!ok || last_pt !== exp_pt || last_key !== exp_key) begin
                n_err++; $display("FAIL rand_job%0d got=%h %h want=%h %h", j, last_pt, last_key, exp_pt, exp_key);
            end
            repeat ($urandom_range(0, 15)) @(negedge clk);
            pulse_done();
            @(negedge clk);
            n_vec++;
            if (job_count !== JOB_CNT_W'(m_jobs) || start_cnt != s0 + 1) begin
                n_err++; $display("FAIL rand_count%0d got jc=%0d starts=%0d want jc=%0d starts=1",
                                  j, job_count, start_cnt - s0, m_jobs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_key_reuse();
        test_reuse_before_key();
        test_back_to_back();
        test_reset_mid_stream();
        test_spurious_done();
        test_random_jobs();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
